fp_add_issue_stage: RTL and testbench

//  Request-side stage in front of the single-cycle-registered FloatingAdd unit.

---
 rtl/fp_add_pkg.sv | 32 +++
 rtl/fp_add_issue_stage_if.sv | 32 +++
 rtl/fp_result_fifo.sv | 60 ++++++
 rtl/fp_add_issue_stage.sv | 135 +++++++++++++
 tb/tb_fp_add_issue_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_pkg.sv
// FP32 field layout and zero-operand helpers shared by the FloatingAdd issue stage.
package fp_add_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  // A zero exponent (true zero or denormal) is treated as zero.
  function automatic logic fp_is_zero(fp32_t v);
    return v.exp == '0;
  endfunction

  // Result of A +/- B when at least one operand is zero.
  function automatic fp32_t fp_zero_result(fp32_t a, fp32_t b, logic negate);
    fp32_t r;
    if (fp_is_zero(a) && fp_is_zero(b)) begin
      r = '0;
    end else if (fp_is_zero(a)) begin
      r = '{sign: b.sign ^ negate, exp: b.exp, man: b.man};
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_add_issue_stage_if.sv
// Request and response handshakes of the FloatingAdd issue stage.
interface fp_add_issue_stage_if #(
  parameter int TAG_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_negate;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_negate, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_a, req_b, req_negate, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Synchronous result FIFO; push is never checked against full because the caller holds credits.
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_add_issue_stage.sv
// Issue stage in front of the registered FloatingAdd unit: credit-limited accept, in-order tagged results.
// Optional build macro FP_ADD_ZERO_BYPASS_EN short-circuits zero operands past the adder result.
module fp_add_issue_stage
  import fp_add_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int ADD_LAT      = 1,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_add_issue_stage_if.slave  io,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_negate,
  input  logic [31:0]          add_result,
  output logic                 busy
);

  localparam int PIPE_D = ADD_LAT + 1;
  localparam int CNT_W  = $clog2(RESULT_DEPTH + 1);

  typedef struct packed {
    fp32_t            data;
    logic [TAG_W-1:0] tag;
  } fp_rsp_t;

  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] fifo_count;
  fp32_t            add_a_q, add_b_q;
  logic             add_negate_q;
  logic [PIPE_D-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [PIPE_D];
  fp32_t            wr_data;
  fp_rsp_t          fifo_wdata, fifo_rdata;

  // Credit is taken from registered occupancy only, so rsp_ready never reaches req_ready.
  assign io.req_ready = !reset && (occ_q < CNT_W'(RESULT_DEPTH));
  assign accept       = io.req_valid && io.req_ready;
  assign pop          = io.rsp_valid && io.rsp_ready;
  assign busy         = occ_q != '0;

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_negate_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (accept) begin
        add_a_q      <= io.req_a;
        add_b_q      <= io.req_b;
        add_negate_q <= io.req_negate;
      end
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_negate = add_negate_q;

  // Valid/tag pipe matches the adder latency; a zero bit discards that cycle's adder output.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_D; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= io.req_tag;
      for (int i = 1; i < PIPE_D; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

`ifdef FP_ADD_ZERO_BYPASS_EN
  logic [PIPE_D-1:0] byp_q;
  fp32_t             byp_data_q [PIPE_D];

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_q <= '0;
      for (int i = 0; i < PIPE_D; i++) byp_data_q[i] <= '0;
    end else begin
      byp_q[0]      <= fp_is_zero(io.req_a) || fp_is_zero(io.req_b);
      byp_data_q[0] <= fp_zero_result(io.req_a, io.req_b, io.req_negate);
      for (int i = 1; i < PIPE_D; i++) begin
        byp_q[i]      <= byp_q[i-1];
        byp_data_q[i] <= byp_data_q[i-1];
      end
    end
  end

  assign wr_data = byp_q[PIPE_D-1] ? byp_data_q[PIPE_D-1] : fp32_t'(add_result);
`else
  assign wr_data = fp32_t'(add_result);
`endif

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.data = wr_data;
    fifo_wdata.tag  = tag_q[PIPE_D-1];
  end

  fp_result_fifo #(
    .DEPTH (RESULT_DEPTH),
    .WIDTH ($bits(fp_rsp_t))
  ) u_result_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (vld_q[PIPE_D-1]),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign io.rsp_valid = fifo_count != '0;
  assign io.rsp_data  = fifo_rdata.data;
  assign io.rsp_tag   = fifo_rdata.tag;

endmodule

// File: tb/tb_fp_add_issue_stage.sv
// Directed bench for fp_add_issue_stage: latency, credit back-pressure, ordering, reset flush, zero bypass.
module tb_fp_add_issue_stage;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] add_a, add_b, add_result;
  logic        add_negate;
  logic        busy;

  int n_cmp   = 0;
  int n_err   = 0;
  int occ_mdl = 0;
  int max_occ = 0;

  fp_add_issue_stage_if #(.TAG_W(TAG_W)) io ();

  fp_add_issue_stage #(
    .TAG_W        (TAG_W),
    .ADD_LAT      (1),
    .RESULT_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io         (io),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_negate (add_negate),
    .add_result (add_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the FloatingAdd unit: one register stage, exact for 1.0+2.0,
  // plain integer arithmetic otherwise so every result is distinguishable.
  function automatic logic [31:0] adder_model(logic [31:0] a, logic [31:0] b, logic neg);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !neg) return 32'h4040_0000;
    return neg ? a - b : a + b;
  endfunction

  always @(posedge clk) add_result <= adder_model(add_a, add_b, add_negate);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic neg,
                           input logic [TAG_W-1:0] tag);
    io.req_valid  = 1'b1;
    io.req_a      = a;
    io.req_b      = b;
    io.req_negate = neg;
    io.req_tag    = tag;
  endtask

  // Occupancy as seen at the ports, sampled just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      occ_mdl = 0;
    end else begin
      if (io.req_valid && io.req_ready) occ_mdl++;
      if (io.rsp_valid && io.rsp_ready) occ_mdl--;
    end
    if (occ_mdl > max_occ) max_occ = occ_mdl;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rsp_seen;
    logic [31:0] exp_z1, exp_z2;

    reset         = 1'b1;
    io.req_valid  = 1'b0;
    io.req_a      = '0;
    io.req_b      = '0;
    io.req_negate = 1'b0;
    io.req_tag    = '0;
    io.rsp_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", io.req_ready, 0);
    check("rst_rsp_valid", io.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_negate", add_negate, 0);
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", io.req_ready, 1);

    // 1.0 + 2.0, result two cycles after the accept edge
    io.rsp_ready = 1'b1;
    drive_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3);
    @(negedge clk);
    io.req_valid = 1'b0;
    check("t1_add_a", add_a, 32'h3F80_0000);
    check("t1_add_b", add_b, 32'h4000_0000);
    check("t1_valid_early", io.rsp_valid, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_valid_lat1", io.rsp_valid, 0);
    @(negedge clk);
    check("t1_valid_lat2", io.rsp_valid, 1);
    check("t1_data", io.rsp_data, 32'h4040_0000);
    check("t1_tag", io.rsp_tag, 3);
    @(negedge clk);
    check("t1_popped", io.rsp_valid, 0);
    check("t1_idle", busy, 0);
    check("t1_add_a_hold", add_a, 32'h3F80_0000);

    // Back-pressure: four accepted, fifth held off
    io.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ready_%0d", i), io.req_ready, 1);
      drive_req(32'h10 * (i + 1), 32'h100, 1'b0, TAG_W'(i));
      @(negedge clk);
    end
    check("t2_full_ready", io.req_ready, 0);
    drive_req(32'h50, 32'h100, 1'b0, 4'd4);
    repeat (3) @(negedge clk);
    check("t2_held_ready", io.req_ready, 0);
    check("t2_head_valid", io.rsp_valid, 1);
    check("t2_head_tag0", io.rsp_tag, 0);
    check("t2_head_data0", io.rsp_data, 32'h110);

    // Pop and request in the same cycle while full: pop only, accept one cycle later
    io.rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_one_pop_tag", io.rsp_tag, 1);
    check("t3_one_pop_data", io.rsp_data, 32'h120);
    check("t3_credit_back", io.req_ready, 1);
    @(negedge clk);
    check("t2_tag2", io.rsp_tag, 2);
    check("t2_data2", io.rsp_data, 32'h130);
    check("t2_ready_tag5", io.req_ready, 1);
    drive_req(32'h60, 32'h100, 1'b0, 4'd5);
    @(negedge clk);
    io.req_valid = 1'b0;
    check("t2_tag3", io.rsp_tag, 3);
    check("t2_data3", io.rsp_data, 32'h140);
    @(negedge clk);
    check("t2_tag4", io.rsp_tag, 4);
    check("t2_data4", io.rsp_data, 32'h150);
    @(negedge clk);
    check("t2_tag5", io.rsp_tag, 5);
    check("t2_data5", io.rsp_data, 32'h160);
    @(negedge clk);
    check("t2_drained", io.rsp_valid, 0);
    check("t2_idle", busy, 0);

    // Reset one cycle after two accepts drops everything in flight
    io.rsp_ready = 1'b0;
    drive_req(32'h1, 32'h2, 1'b0, 4'd8);
    @(negedge clk);
    drive_req(32'h3, 32'h4, 1'b0, 4'd9);
    @(negedge clk);
    io.req_valid = 1'b0;
    reset        = 1'b1;
    rsp_seen     = io.rsp_valid;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_ready", io.req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      rsp_seen = rsp_seen | io.rsp_valid;
      @(negedge clk);
    end
    check("t4_no_rsp", rsp_seen, 0);
    check("t4_still_idle", busy, 0);

    // Zero operands
`ifdef FP_ADD_ZERO_BYPASS_EN
    exp_z1 = 32'hC0A0_0000;
    exp_z2 = 32'h40A0_0000;
`else
    exp_z1 = 32'hBF60_0000;
    exp_z2 = 32'hC0A0_0000;
`endif
    io.rsp_ready = 1'b1;
    drive_req(32'h0000_0000, 32'h40A0_0000, 1'b1, 4'd6);
    @(negedge clk);
    drive_req(32'h40A0_0000, 32'h8000_0000, 1'b0, 4'd7);
    @(negedge clk);
    io.req_valid = 1'b0;
    check("t5_valid_early", io.rsp_valid, 0);
    @(negedge clk);
    check("t5_valid0", io.rsp_valid, 1);
    check("t5_tag0", io.rsp_tag, 6);
    check("t5_data0", io.rsp_data, exp_z1);
    @(negedge clk);
    check("t5_tag1", io.rsp_tag, 7);
    check("t5_data1", io.rsp_data, exp_z2);
    @(negedge clk);
    check("t5_drained", io.rsp_valid, 0);
    check("t5_idle", busy, 0);

    check("max_occupancy", max_occ, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
